// File: rtl/fifo_capture_ctrl_if.sv
// Stream-source and sample-FIFO signal bundle for the capture controller.
// master = capture controller side, slave = source/FIFO side.
interface fifo_capture_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_wrreq;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rdreq;

  modport master (
    input  src_data, src_valid, fifo_full, fifo_empty, fifo_rdreq,
    output fifo_data, fifo_wrreq
  );

  modport slave (
    output src_data, src_valid, fifo_full, fifo_empty, fifo_rdreq,
    input  fifo_data, fifo_wrreq
  );
endinterface

// File: rtl/fifo_capture_ctrl.sv
// Sequences block captures from a stream into the sample FIFO and tracks its occupancy.
// Define FIFO_CAPTURE_DECIM_EN to add input decimation (i_cfg_decim).
module fifo_capture_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned LVL_W  = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [CNT_W-1:0]    i_cfg_length,
  input  logic                i_cfg_trig_en,
`ifdef FIFO_CAPTURE_DECIM_EN
  input  logic [7:0]          i_cfg_decim,
`endif
  input  logic                i_trig_in,
  fifo_capture_ctrl_if.master bus,
  output logic [LVL_W-1:0]    o_level,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_length;
  logic [CNT_W-1:0]  r_count;
  logic              r_trig_d;
  logic              r_wrreq;
  logic [DATA_W-1:0] r_data;
  logic [LVL_W-1:0]  r_level;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;

  logic w_eff_wr;
  logic w_eff_rd;
  logic w_space;
  logic w_cand;
  logic w_accept;

  // Space counts the write already in flight so a full FIFO is never overrun.
  assign w_eff_wr = r_wrreq & ~bus.fifo_full;
  assign w_eff_rd = bus.fifo_rdreq & ~bus.fifo_empty;
  assign w_space  = ({1'b0, r_level} + (LVL_W+1)'(r_wrreq)) < (LVL_W+1)'(DEPTH);

`ifdef FIFO_CAPTURE_DECIM_EN
  logic [7:0] r_decim;
  logic [7:0] r_dcnt;
  assign w_cand = bus.src_valid & (r_dcnt == 8'd0);
`else
  assign w_cand = bus.src_valid;
`endif

  assign w_accept = (r_state == S_CAPTURE) & w_cand & w_space;

  // Occupancy tracker, saturating at 0 and DEPTH; runs in every state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_level <= '0;
    end else if (w_eff_wr && !w_eff_rd && (r_level < LVL_W'(DEPTH))) begin
      r_level <= r_level + LVL_W'(1);
    end else if (w_eff_rd && !w_eff_wr && (r_level != '0)) begin
      r_level <= r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_length   <= '0;
      r_count    <= '0;
      r_trig_d   <= 1'b0;
      r_wrreq    <= 1'b0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
`ifdef FIFO_CAPTURE_DECIM_EN
      r_decim    <= '0;
      r_dcnt     <= '0;
`endif
    end else begin
      r_trig_d <= i_trig_in;
      r_wrreq  <= 1'b0;
      if (w_accept && !i_abort) begin
        r_wrreq <= 1'b1;
        r_data  <= bus.src_data;
      end

      if (i_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_length   <= i_cfg_length;
              r_count    <= '0;
              r_done     <= 1'b0;
              r_overflow <= 1'b0;
              r_busy     <= 1'b1;
`ifdef FIFO_CAPTURE_DECIM_EN
              r_decim    <= i_cfg_decim;
              r_dcnt     <= '0;
`endif
              if (i_cfg_length == '0) begin
                r_state <= S_DONE;
              end else if (i_cfg_trig_en) begin
                r_state <= S_ARMED;
              end else begin
                r_state <= S_CAPTURE;
              end
            end
          end
          S_ARMED: begin
            // The edge cycle itself is not sampled; capture begins on the next one.
            if (i_trig_in && !r_trig_d) begin
              r_state <= S_CAPTURE;
`ifdef FIFO_CAPTURE_DECIM_EN
              r_dcnt  <= '0;
`endif
            end
          end
          S_CAPTURE: begin
`ifdef FIFO_CAPTURE_DECIM_EN
            if (bus.src_valid) begin
              r_dcnt <= (r_dcnt == r_decim) ? 8'd0 : r_dcnt + 8'd1;
            end
`endif
            if (w_cand && !w_space) begin
              r_overflow <= 1'b1;
            end
            if (w_accept) begin
              r_count <= r_count + CNT_W'(1);
              if ((r_count + CNT_W'(1)) == r_length) begin
                r_state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end

      if (r_wrreq && bus.fifo_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.fifo_data  = r_data;
  assign bus.fifo_wrreq = r_wrreq;
  assign o_level        = r_level;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_fifo_capture_ctrl.sv
// Self-checking bench for fifo_capture_ctrl with a queue-based FIFO and capture model.
// Decimation checks are included when FIFO_CAPTURE_DECIM_EN is defined.
`timescale 1ns/1ps
module tb_fifo_capture_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2048;
  localparam int LVL_W  = 12;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort, cfg_trig_en, trig_in;
  logic [CNT_W-1:0] cfg_length;
`ifdef FIFO_CAPTURE_DECIM_EN
  logic [7:0]       cfg_decim;
`endif
  logic [LVL_W-1:0] level;
  logic             busy, done, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_capture_ctrl_if #(.DATA_W(DATA_W)) bus ();

  fifo_capture_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W), .CNT_W(CNT_W)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_cfg_length(cfg_length), .i_cfg_trig_en(cfg_trig_en),
`ifdef FIFO_CAPTURE_DECIM_EN
    .i_cfg_decim(cfg_decim),
`endif
    .i_trig_in(trig_in), .bus(bus),
    .o_level(level), .o_busy(busy), .o_done(done), .o_overflow(overflow)
  );

  // Behavioural FIFO: real occupancy plus a log of every write request seen.
  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] wr_log[$];
  int fq_n = 0;
  assign bus.fifo_full  = (fq_n >= DEPTH);
  assign bus.fifo_empty = (fq_n == 0);

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
    end else begin
      if (bus.fifo_rdreq && !bus.fifo_empty) void'(fq.pop_front());
      if (bus.fifo_wrreq && !bus.fifo_full) fq.push_back(bus.fifo_data);
      if (bus.fifo_wrreq) wr_log.push_back(bus.fifo_data);
    end
    fq_n <= fq.size();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; the tracked level must always equal the real occupancy.
  task automatic tick();
    @(posedge clk); #1;
    check("level_vs_fifo", 64'(level), 64'(fq.size()));
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; cfg_length = '0; cfg_trig_en = 0; trig_in = 0;
    bus.src_valid = 0; bus.src_data = '0; bus.fifo_rdreq = 0;
`ifdef FIFO_CAPTURE_DECIM_EN
    cfg_decim = '0;
`endif
  endtask

  task automatic drain();
    bus.src_valid = 0; bus.fifo_rdreq = 1;
    for (int i = 0; i < 3000 && level != '0; i++) tick();
    bus.fifo_rdreq = 0;
    check("drain_level", 64'(level), 64'd0);
  endtask

  int unsigned dseq = 0;

  // Continuous-valid capture without trigger; waits for done within a budget.
  task automatic capture_cont(input int len);
    bit ok = 0;
    start = 1; cfg_length = CNT_W'(len); cfg_trig_en = 0; bus.src_valid = 0;
    tick();
    start = 0;
    for (int i = 0; i < len + 20; i++) begin
      bus.src_valid = 1; bus.src_data = dseq; dseq++;
      tick();
      if (done) begin ok = 1; break; end
    end
    bus.src_valid = 0;
    check("capture_cont_done", 64'(ok), 64'd1);
  endtask

  typedef struct {
    logic             start, abort;
    logic [CNT_W-1:0] len;
    logic             trig_en, valid;
    logic [DATA_W-1:0] data;
    logic             rdreq;
    logic             e_wr;
    logic [DATA_W-1:0] e_data;
    logic             e_busy, e_done, e_ovf;
    logic [LVL_W-1:0] e_level;
  } vec_t;

  function automatic vec_t v(input int s, a, ln, te, vl, dt, rd, ew, ed, eb, edn, eo, el);
    vec_t r;
    r.start = 1'(s); r.abort = 1'(a); r.len = CNT_W'(ln); r.trig_en = 1'(te);
    r.valid = 1'(vl); r.data = DATA_W'(dt); r.rdreq = 1'(rd);
    r.e_wr = 1'(ew); r.e_data = DATA_W'(ed); r.e_busy = 1'(eb);
    r.e_done = 1'(edn); r.e_ovf = 1'(eo); r.e_level = LVL_W'(el);
    return r;
  endfunction

  vec_t vt[14];
  logic [DATA_W-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lv;
    bit ok;
    bit all_ten;

    //            st ab len te vl data  rd  wr edata bsy dn ov lvl
    vt[0]  = v(0, 0, 0,  0, 0, 0,    0,  0, 0,    0, 0, 0, 0);
    vt[1]  = v(1, 0, 3,  0, 1, 'hA0, 0,  0, 0,    1, 0, 0, 0);
    vt[2]  = v(0, 0, 0,  0, 1, 'h11, 0,  1, 'h11, 1, 0, 0, 0);
    vt[3]  = v(0, 0, 0,  0, 1, 'h22, 0,  1, 'h22, 1, 0, 0, 1);
    vt[4]  = v(0, 0, 0,  0, 0, 'h33, 0,  0, 'h22, 1, 0, 0, 2);
    vt[5]  = v(0, 0, 0,  0, 1, 'h44, 0,  1, 'h44, 1, 0, 0, 2);
    vt[6]  = v(1, 0, 3,  0, 1, 'h55, 0,  0, 'h44, 0, 1, 0, 3);
    vt[7]  = v(0, 0, 0,  0, 0, 0,    1,  0, 'h44, 0, 1, 0, 2);
    vt[8]  = v(1, 0, 0,  0, 0, 0,    0,  0, 'h44, 1, 0, 0, 2);
    vt[9]  = v(0, 0, 0,  0, 0, 0,    0,  0, 'h44, 0, 1, 0, 2);
    vt[10] = v(1, 0, 16, 0, 1, 'h60, 0,  0, 'h44, 1, 0, 0, 2);
    vt[11] = v(0, 0, 0,  0, 1, 'h61, 0,  1, 'h61, 1, 0, 0, 2);
    vt[12] = v(1, 1, 16, 0, 1, 'h62, 0,  0, 'h61, 0, 0, 0, 3);
    vt[13] = v(0, 0, 0,  0, 1, 'h63, 0,  0, 'h61, 0, 0, 0, 3);

    idle_inputs();
    rst = 1;
    repeat (3) tick();
    check("rst_wrreq", 64'(bus.fifo_wrreq), 64'd0);
    check("rst_data",  64'(bus.fifo_data),  64'd0);
    check("rst_level", 64'(level),          64'd0);
    check("rst_busy",  64'(busy),           64'd0);
    check("rst_done",  64'(done),           64'd0);
    check("rst_ovf",   64'(overflow),       64'd0);
    rst = 0;

    // Directed vectors: short capture, start in DONE, zero length, abort with start.
    for (int i = 0; i < 14; i++) begin
      start = vt[i].start; abort = vt[i].abort; cfg_length = vt[i].len;
      cfg_trig_en = vt[i].trig_en; bus.src_valid = vt[i].valid;
      bus.src_data = vt[i].data; bus.fifo_rdreq = vt[i].rdreq;
      tick();
      check($sformatf("vec%0d_wrreq", i), 64'(bus.fifo_wrreq), 64'(vt[i].e_wr));
      check($sformatf("vec%0d_data", i),  64'(bus.fifo_data),  64'(vt[i].e_data));
      check($sformatf("vec%0d_busy", i),  64'(busy),           64'(vt[i].e_busy));
      check($sformatf("vec%0d_done", i),  64'(done),           64'(vt[i].e_done));
      check($sformatf("vec%0d_ovf", i),   64'(overflow),       64'(vt[i].e_ovf));
      check($sformatf("vec%0d_level", i), 64'(level),          64'(vt[i].e_level));
    end
    idle_inputs();

    // Length-8 capture with data 0..: first write two cycles after start.
    base = wr_log.size(); lv = int'(level);
    start = 1; cfg_length = 16'd8; bus.src_valid = 1; bus.src_data = 32'hFFFF;
    tick();
    start = 0;
    check("len8_no_wr_c1", 64'(bus.fifo_wrreq), 64'd0);
    for (int d = 0; d < 20; d++) begin
      bus.src_data = DATA_W'(d);
      tick();
      if (d == 0) begin
        check("len8_first_wr",   64'(bus.fifo_wrreq), 64'd1);
        check("len8_first_data", 64'(bus.fifo_data),  64'd0);
      end
      if (done) break;
    end
    bus.src_valid = 0;
    check("len8_nwrites", 64'(wr_log.size() - base), 64'd8);
    for (int i = 0; i < 8 && base + i < wr_log.size(); i++)
      check($sformatf("len8_data%0d", i), 64'(wr_log[base+i]), 64'(i));
    check("len8_done",  64'(done),  64'd1);
    check("len8_busy",  64'(busy),  64'd0);
    check("len8_level", 64'(level), 64'(lv + 8));

    // Trigger: rises 10 cycles after start; the edge-cycle sample is skipped.
    base = wr_log.size();
    cfg_trig_en = 1; cfg_length = 16'd4;
    for (int k = 0; k < 40; k++) begin
      start = (k == 0); trig_in = (k >= 10);
      bus.src_valid = 1; bus.src_data = DATA_W'(100 + k);
      tick();
      if (k == 5) begin
        check("trig_armed_busy", 64'(busy), 64'd1);
        check("trig_armed_nowr", 64'(wr_log.size() - base), 64'd0);
      end
      if (done) break;
    end
    idle_inputs();
    check("trig_nwrites", 64'(wr_log.size() - base), 64'd4);
    for (int i = 0; i < 4 && base + i < wr_log.size(); i++)
      check($sformatf("trig_data%0d", i), 64'(wr_log[base+i]), 64'(111 + i));
    check("trig_done", 64'(done), 64'd1);

    // Near-full FIFO: prefill to 2046, then only two of five samples fit.
    drain();
    capture_cont(2046);
    check("prefill_level", 64'(level), 64'd2046);
    base = wr_log.size();
    start = 1; cfg_length = 16'd5;
    tick();
    start = 0;
    for (int i = 0; i < 10; i++) begin
      bus.src_valid = 1; bus.src_data = DATA_W'(500 + i);
      tick();
    end
    check("full_nwrites", 64'(wr_log.size() - base), 64'd2);
    check("full_data0",   64'(wr_log[base]),   64'd500);
    check("full_data1",   64'(wr_log[base+1]), 64'd501);
    check("full_level",   64'(level),    64'd2048);
    check("full_ovf",     64'(overflow), 64'd1);
    check("full_busy",    64'(busy),     64'd1);
    check("full_notdone", 64'(done),     64'd0);
    bus.fifo_rdreq = 1; ok = 0;
    for (int i = 0; i < 50; i++) begin
      bus.src_valid = 1; bus.src_data = DATA_W'(600 + i);
      tick();
      if (done) begin ok = 1; break; end
    end
    bus.src_valid = 0; bus.fifo_rdreq = 0;
    check("full_resume_done", 64'(ok), 64'd1);
    check("full_resume_nwr",  64'(wr_log.size() - base), 64'd5);
    check("full_ovf_sticky",  64'(overflow), 64'd1);

    // Write and read every cycle for 100 cycles at level 10.
    drain();
    capture_cont(10);
    check("wr_rd_start_level", 64'(level), 64'd10);
    start = 1; cfg_length = 16'd100;
    tick();
    start = 0; all_ten = 1;
    for (int i = 0; i <= 100; i++) begin
      bus.src_valid = (i < 100); bus.src_data = DATA_W'(i);
      bus.fifo_rdreq = (i >= 1);
      tick();
      if (level != LVL_W'(10)) all_ten = 0;
    end
    bus.src_valid = 0; bus.fifo_rdreq = 0;
    tick();
    check("wr_rd_level_steady", 64'(all_ten), 64'd1);
    check("wr_rd_done",         64'(done),    64'd1);
    check("wr_rd_level_end",    64'(level),   64'd10);
    bus.fifo_rdreq = 1;
    repeat (15) tick();
    bus.fifo_rdreq = 0;
    check("read_empty_level", 64'(level), 64'd0);

    // Reset in the middle of a capture.
    start = 1; cfg_length = 16'd16;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      bus.src_valid = 1; bus.src_data = DATA_W'(700 + i); tick();
    end
    rst = 1;
    tick();
    rst = 0;
    check("midrst_wrreq", 64'(bus.fifo_wrreq), 64'd0);
    check("midrst_data",  64'(bus.fifo_data),  64'd0);
    check("midrst_busy",  64'(busy),           64'd0);
    check("midrst_level", 64'(level),          64'd0);
    tick();
    check("midrst_nowr",  64'(bus.fifo_wrreq), 64'd0);
    check("midrst_idle",  64'(busy),           64'd0);
    idle_inputs();

`ifdef FIFO_CAPTURE_DECIM_EN
    // Decimation by 3: first candidate is the first sample after entering CAPTURE.
    base = wr_log.size();
    start = 1; cfg_length = 16'd3; cfg_decim = 8'd2;
    tick();
    start = 0;
    for (int d = 0; d < 30; d++) begin
      bus.src_valid = 1; bus.src_data = DATA_W'(d);
      tick();
      if (done) break;
    end
    idle_inputs();
    check("decim_nwrites", 64'(wr_log.size() - base), 64'd3);
    for (int i = 0; i < 3 && base + i < wr_log.size(); i++)
      check($sformatf("decim_data%0d", i), 64'(wr_log[base+i]), 64'(3 * i));
    check("decim_done", 64'(done), 64'd1);
`endif

    // Random captures against a transaction-level model of which samples get taken.
    for (int run = 0; run < 25; run++) begin
      int len;
      int got;
      bit te;
      bit waiting;
      bit prev_trig;
      bit same;
      len = int'($urandom_range(1, 12));
      te = 1'($urandom_range(0, 1));
      exp_q.delete();
      base = wr_log.size();
      start = 1; cfg_length = CNT_W'(len); cfg_trig_en = te;
      bus.src_valid = 1'($urandom_range(0, 1)); bus.src_data = $urandom;
      bus.fifo_rdreq = 1'($urandom_range(0, 1));
      tick();
      start = 0;
      prev_trig = trig_in; waiting = te; got = 0;
      for (int c = 0; c < 300 && got < len; c++) begin
        bus.src_valid = 1'($urandom_range(0, 1));
        bus.src_data = $urandom;
        bus.fifo_rdreq = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
        if (waiting) begin
          if (trig_in && !prev_trig) waiting = 0;
        end else if (bus.src_valid) begin
          exp_q.push_back(bus.src_data);
          got++;
        end
        prev_trig = trig_in;
        tick();
      end
      if (got < len) begin
        check($sformatf("rnd%0d_timeout", run), 64'(got), 64'(len));
        abort = 1; tick(); abort = 0;
      end
      bus.src_valid = 0;
      tick();
      check($sformatf("rnd%0d_done", run), 64'(done), 64'd1);
      check($sformatf("rnd%0d_busy", run), 64'(busy), 64'd0);
      check($sformatf("rnd%0d_ovf", run),  64'(overflow), 64'd0);
      check($sformatf("rnd%0d_nwr", run),  64'(wr_log.size() - base), 64'(exp_q.size()));
      same = 1;
      for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++)
        if (wr_log[base+i] !== exp_q[i]) same = 0;
      check($sformatf("rnd%0d_data", run), 64'(same), 64'd1);
      repeat (int'($urandom_range(1, 4))) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
